// File: rtl/down_counter_borrow.sv
// Loadable, cascadable down counter with borrow chain, one-shot and auto-reload modes.
// Latency: A and Done update one edge after the enabling inputs; B_out is combinational.
// Backpressure: none. Count and B_in gate each step; Load and Clear always take effect.
module down_counter_borrow #(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b0,
    parameter bit ONE_SHOT    = 1'b0
) (
    input  logic             CLK,
    input  logic             Clear,
    input  logic             Load,
    input  logic             Count,
    input  logic             B_in,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] A,
    output logic             B_out,
    output logic             Done,
    output logic             Expired
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] reload_reg;
    logic             dec;
    logic             at_zero;

    // A step happens only while running, enabled, borrowed into, and not overridden by a load.
    assign at_zero = (A == '0);
    assign dec     = Count & B_in & ~Load & (state == ST_RUN);

    // State register; Clear forces IDLE from any state.
    always_ff @(posedge CLK) begin
        if (Clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a load always (re)starts counting; a one-shot underflow parks in EXPIRED.
    always_comb begin
        state_nxt = state;
        if (Load) begin
            state_nxt = ST_RUN;
        end else if (dec && at_zero && ONE_SHOT) begin
            state_nxt = ST_EXPIRED;
        end
    end

    // Count value, reload value and the registered underflow pulse.
    always_ff @(posedge CLK) begin
        if (Clear) begin
            A          <= '0;
            reload_reg <= '0;
            Done       <= 1'b0;
        end else if (Load) begin
            A          <= I;
            reload_reg <= I;
            Done       <= 1'b0;
        end else if (dec) begin
            Done <= at_zero;
            if (!at_zero) begin
                A <= A - WIDTH'(1);
            end else if (ONE_SHOT) begin
                A <= '0;
            end else if (AUTO_RELOAD) begin
                A <= reload_reg;
            end else begin
                A <= '1;
            end
        end else begin
            Done <= 1'b0;
        end
    end

    // Outputs: borrow fires in the same cycle the underflowing step is enabled.
    always_comb begin
        B_out   = dec & at_zero;
        Expired = (state == ST_EXPIRED);
    end

endmodule
